// File: rtl/apb3_master_if.sv
// Command/response port and APB3 bus signals of the APB requester.
// master: the requester side; slave: the command source and APB completer side.
interface apb3_master_if #(
    parameter int N_BIT_DATA    = 32,
    parameter int N_BIT_ADDRESS = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [N_BIT_ADDRESS-1:0] cmd_addr;
    logic [N_BIT_DATA-1:0]    cmd_wdata;

    logic                     rsp_valid;
    logic [N_BIT_DATA-1:0]    rsp_rdata;
    logic                     rsp_err;
    logic                     rsp_timeout;

    logic                     PSEL;
    logic                     PENABLE;
    logic                     PWRITE;
    logic [N_BIT_ADDRESS-1:0] PADDR;
    logic [N_BIT_DATA-1:0]    PWDATA;
    logic [N_BIT_DATA-1:0]    PRDATA;
    logic                     PREADY;
    logic                     PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb3_master.sv
// AMBA 3 APB requester: runs one command at a time as SETUP + ACCESS,
// honours PREADY wait states and aborts stalled transfers after a timeout.
module apb3_master #(
    parameter int N_BIT_DATA     = 32,
    parameter int N_BIT_ADDRESS  = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int N_BIT_TIMEOUT  = 8
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb3_master_if.master apb
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam bit LP_TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [N_BIT_TIMEOUT-1:0] LP_TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : N_BIT_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_t                   r_state;
    logic [N_BIT_TIMEOUT-1:0] r_wait_cnt;
    logic                     r_psel;
    logic                     r_penable;
    logic                     r_pwrite;
    logic [N_BIT_ADDRESS-1:0] r_paddr;
    logic [N_BIT_DATA-1:0]    r_pwdata;
    logic                     r_rsp_valid;
    logic [N_BIT_DATA-1:0]    r_rsp_rdata;
    logic                     r_rsp_err;
    logic                     r_rsp_timeout;
    logic                     w_cmd_ready;

    assign w_cmd_ready = (r_state == S_IDLE) && !PRESET;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (apb.cmd_valid && w_cmd_ready) begin
                        r_paddr    <= apb.cmd_addr;
                        r_pwrite   <= apb.cmd_write;
                        r_pwdata   <= apb.cmd_write ? apb.cmd_wdata : '0;
                        r_wait_cnt <= '0;
                        r_psel     <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // Completion takes priority over a timeout on the same edge.
                    if (apb.PREADY) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= S_IDLE;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= apb.PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : apb.PRDATA;
                    end else if (LP_TO_EN && (r_wait_cnt == LP_TO_LAST)) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= S_IDLE;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign apb.cmd_ready   = w_cmd_ready;
    assign apb.rsp_valid   = r_rsp_valid;
    assign apb.rsp_rdata   = r_rsp_rdata;
    assign apb.rsp_err     = r_rsp_err;
    assign apb.rsp_timeout = r_rsp_timeout;
    assign apb.PSEL        = r_psel;
    assign apb.PENABLE     = r_penable;
    assign apb.PWRITE      = r_pwrite;
    assign apb.PADDR       = r_paddr;
    assign apb.PWDATA      = r_pwdata;
endmodule

// File: tb/tb_apb3_master.sv
// Bench for apb3_master: directed and random transfers against a
// transaction-level model of latency, bus phases and response values.
module tb_apb3_master;
    localparam int D  = 32;
    localparam int A  = 4;
    localparam int TO = 4;
    localparam int NT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb3_master_if #(.N_BIT_DATA(D), .N_BIT_ADDRESS(A)) bus_if ();

    apb3_master #(
        .N_BIT_DATA    (D),
        .N_BIT_ADDRESS (A),
        .TIMEOUT_CYCLES(TO),
        .N_BIT_TIMEOUT (NT)
    ) dut (
        .PCLK  (clk),
        .PRESET(rst),
        .apb   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Values the bus/response outputs must hold between transfers.
    logic [A-1:0] last_addr;
    logic         last_write;
    logic [D-1:0] last_wdata;
    logic [D-1:0] last_rdata;
    logic         last_err;
    logic         last_to;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psel"},   64'(bus_if.PSEL), 64'd0);
        check({tag, "_pen"},    64'(bus_if.PENABLE), 64'd0);
        check({tag, "_pwrite"}, 64'(bus_if.PWRITE), 64'd0);
        check({tag, "_paddr"},  64'(bus_if.PADDR), 64'd0);
        check({tag, "_pwdata"}, 64'(bus_if.PWDATA), 64'd0);
        check({tag, "_rvalid"}, 64'(bus_if.rsp_valid), 64'd0);
        check({tag, "_rerr"},   64'(bus_if.rsp_err), 64'd0);
        check({tag, "_rto"},    64'(bus_if.rsp_timeout), 64'd0);
        check({tag, "_rdata"},  64'(bus_if.rsp_rdata), 64'd0);
        check({tag, "_ready"},  64'(bus_if.cmd_ready), 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_psel",   64'(bus_if.PSEL), 64'd0);
            check("idle_pen",    64'(bus_if.PENABLE), 64'd0);
            check("idle_rvalid", 64'(bus_if.rsp_valid), 64'd0);
            check("idle_ready",  64'(bus_if.cmd_ready), 64'd1);
            check("idle_paddr",  64'(bus_if.PADDR), 64'(last_addr));
            check("idle_pwrite", 64'(bus_if.PWRITE), 64'(last_write));
            check("idle_pwdata", 64'(bus_if.PWDATA), 64'(last_wdata));
            check("hold_rdata",  64'(bus_if.rsp_rdata), 64'(last_rdata));
            check("hold_rerr",   64'(bus_if.rsp_err), 64'(last_err));
            check("hold_rto",    64'(bus_if.rsp_timeout), 64'(last_to));
        end
    endtask

    // Starts at a negedge with the master idle; returns at the negedge of the
    // response cycle, so a following call issues a back-to-back command.
    // waits = PREADY-low ACCESS cycles the slave inserts before completing.
    task automatic run_txn(input logic wr, input logic [A-1:0] addr, input logic [D-1:0] wdata,
                           input int waits, input logic err, input logic [D-1:0] rdata,
                           input bit hold);
        bit           exp_to;
        int           n_acc;
        logic [D-1:0] exp_pw;
        logic [D-1:0] exp_rd;
        exp_to = (waits >= TO);
        n_acc  = exp_to ? TO : waits + 1;
        exp_pw = wr ? wdata : '0;
        exp_rd = (exp_to || wr) ? '0 : rdata;

        check("start_ready", 64'(bus_if.cmd_ready), 64'd1);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_wdata = wdata;
        bus_if.PREADY    = 1'b0;

        @(negedge clk);
        if (!hold) bus_if.cmd_valid = 1'b0;
        check("setup_psel",   64'(bus_if.PSEL), 64'd1);
        check("setup_pen",    64'(bus_if.PENABLE), 64'd0);
        check("setup_paddr",  64'(bus_if.PADDR), 64'(addr));
        check("setup_pwrite", 64'(bus_if.PWRITE), 64'(wr));
        check("setup_pwdata", 64'(bus_if.PWDATA), 64'(exp_pw));
        check("setup_rvalid", 64'(bus_if.rsp_valid), 64'd0);
        check("setup_ready",  64'(bus_if.cmd_ready), 64'd0);
        // PREADY/PSLVERR/PRDATA are junk here: the master must ignore them in SETUP.
        bus_if.PREADY  = 1'($urandom_range(0, 1));
        bus_if.PSLVERR = 1'($urandom_range(0, 1));
        bus_if.PRDATA  = $urandom;

        for (int k = 0; k < n_acc; k++) begin
            @(negedge clk);
            check("acc_psel",   64'(bus_if.PSEL), 64'd1);
            check("acc_pen",    64'(bus_if.PENABLE), 64'd1);
            check("acc_paddr",  64'(bus_if.PADDR), 64'(addr));
            check("acc_pwrite", 64'(bus_if.PWRITE), 64'(wr));
            check("acc_pwdata", 64'(bus_if.PWDATA), 64'(exp_pw));
            check("acc_rvalid", 64'(bus_if.rsp_valid), 64'd0);
            check("acc_ready",  64'(bus_if.cmd_ready), 64'd0);
            if (k == waits) begin
                bus_if.PREADY  = 1'b1;
                bus_if.PSLVERR = err;
                bus_if.PRDATA  = rdata;
            end else begin
                bus_if.PREADY  = 1'b0;
                bus_if.PSLVERR = 1'($urandom_range(0, 1));
                bus_if.PRDATA  = $urandom;
            end
        end

        @(negedge clk);
        bus_if.PREADY  = 1'b0;
        bus_if.PSLVERR = 1'b0;
        check("rsp_valid",   64'(bus_if.rsp_valid), 64'd1);
        check("rsp_err",     64'(bus_if.rsp_err), 64'(exp_to ? 1'b1 : err));
        check("rsp_timeout", 64'(bus_if.rsp_timeout), 64'(exp_to));
        check("rsp_rdata",   64'(bus_if.rsp_rdata), 64'(exp_rd));
        check("end_psel",    64'(bus_if.PSEL), 64'd0);
        check("end_pen",     64'(bus_if.PENABLE), 64'd0);
        check("end_ready",   64'(bus_if.cmd_ready), 64'd1);
        check("end_paddr",   64'(bus_if.PADDR), 64'(addr));

        last_addr  = addr;
        last_write = wr;
        last_wdata = exp_pw;
        last_rdata = exp_rd;
        last_err   = exp_to ? 1'b1 : err;
        last_to    = exp_to;
        n_txn++;
        $display("txn %0d: %s addr=0x%0h waits=%0d hold=%0d -> err=%0b timeout=%0b rdata=0x%0h",
                 n_txn, wr ? "WR" : "RD", addr, waits, hold, last_err, last_to, exp_rd);
    endtask

    task automatic reset_mid_access();
        check("rst_start_ready", 64'(bus_if.cmd_ready), 64'd1);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = 4'hA;
        bus_if.cmd_wdata = 32'hA5A5_5A5A;
        bus_if.PREADY    = 1'b0;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_acc_pen", 64'(bus_if.PENABLE), 64'd1);
        @(negedge clk);
        check("rst_acc2_pen", 64'(bus_if.PENABLE), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        check("rst_after_rvalid", 64'(bus_if.rsp_valid), 64'd0);
        check("rst_after_psel",   64'(bus_if.PSEL), 64'd0);
        check("rst_after_ready",  64'(bus_if.cmd_ready), 64'd1);
        last_addr  = '0;
        last_write = 1'b0;
        last_wdata = '0;
        last_rdata = '0;
        last_err   = 1'b0;
        last_to    = 1'b0;
        $display("txn %0d: WR addr=0xa dropped by reset during ACCESS", n_txn);
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_wdata = '0;
        bus_if.PRDATA    = '0;
        bus_if.PREADY    = 1'b0;
        bus_if.PSLVERR   = 1'b0;
        last_addr  = '0;
        last_write = 1'b0;
        last_wdata = '0;
        last_rdata = '0;
        last_err   = 1'b0;
        last_to    = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle_cycles(1);

        run_txn(1'b1, 4'h3, 32'hDEAD_BEEF, 0, 1'b0, 32'h1111_2222, 1'b0);
        idle_cycles(1);
        run_txn(1'b0, 4'h5, 32'hFFFF_FFFF, 3, 1'b0, 32'h1234_5678, 1'b0);
        idle_cycles(1);
        run_txn(1'b0, 4'h7, 32'h0, 1, 1'b1, 32'hCAFE_F00D, 1'b0);
        idle_cycles(2);
        run_txn(1'b0, 4'h2, 32'h0, 10, 1'b0, 32'h5555_AAAA, 1'b0);
        idle_cycles(1);
        run_txn(1'b1, 4'h9, 32'h0BAD_F00D, TO - 1, 1'b0, 32'h7777_7777, 1'b0);
        idle_cycles(1);

        for (int i = 0; i < 4; i++) begin
            run_txn(1'(i % 2 == 0), 4'(i + 8), 32'h100 + 32'(i), 0, 1'b0, 32'hBEEF_0000 + 32'(i), 1'b1);
        end
        idle_cycles(1);

        reset_mid_access();
        idle_cycles(1);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                    int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)));
            idle_cycles(int'($urandom_range(0, 2)));
        end
        idle_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
